// File: rtl/bus_sram_slave_if.sv
// Shared burst bus signals seen by one responder: initiator-driven requests and
// responder-driven OR-combinable replies.
interface bus_sram_slave_if;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [7:0]  burstSizeIn;
    logic [3:0]  byteEnablesIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic        busErrorIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;

    modport master (
        output beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn, busErrorIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut
    );

    modport slave (
        input  beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn, busErrorIn,
        output addressDataOut, dataValidOut, endTransactionOut, busErrorOut
    );
endinterface

// File: rtl/bus_sram_slave.sv
// Burst-bus SRAM responder: decodes an address window and serves single/burst
// reads and writes. Define BUS_SRAM_BYTE_ENABLE_EN for per-byte write enables.
module bus_sram_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int unsigned ADDR_BITS    = 9
) (
    input  logic            clock,
    input  logic            reset,
    bus_sram_slave_if.slave bus
);
    localparam int unsigned TAG_LSB = ADDR_BITS + 2;
    localparam int unsigned DEPTH   = 1 << ADDR_BITS;

    typedef enum logic [2:0] {IDLE, READ, READ_END, WRITE, ERROR} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [8:0]           beats_q, beats_d;
    logic                 valid_q, valid_d;
    logic                 end_q, end_d;
    logic                 err_q, err_d;
    logic                 rd_en, wr_en;
    logic                 select, abort;
    logic [3:0]           wr_be;
    logic [31:0]          mem [DEPTH];
    logic [31:0]          rd_data_q;

    assign select = bus.beginTransactionIn &&
                    (bus.addressDataIn[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
    assign abort  = bus.endTransactionIn || bus.busErrorIn;

`ifdef BUS_SRAM_BYTE_ENABLE_EN
    assign wr_be = bus.byteEnablesIn;
`else
    // Forced to all ones; the enables are folded in only so the input is consumed.
    assign wr_be = 4'hF | bus.byteEnablesIn;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        valid_d = 1'b0;
        end_d   = 1'b0;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (select) begin
                    addr_d  = bus.addressDataIn[ADDR_BITS+1:2];
                    beats_d = {1'b0, bus.burstSizeIn} + 9'd1;
                    if (bus.addressDataIn[1:0] != 2'b00) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        end_d   = 1'b1;
                    end else if (bus.readNotWriteIn) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (beats_q != 9'd0) begin
                    // Registered SRAM read: the beat appears on the bus next cycle.
                    rd_en   = 1'b1;
                    valid_d = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    beats_d = beats_q - 9'd1;
                end else begin
                    state_d = READ_END;
                    end_d   = 1'b1;
                end
            end
            READ_END: state_d = IDLE;
            ERROR:    state_d = IDLE;
            WRITE: begin
                if (bus.busErrorIn) begin
                    state_d = IDLE;
                end else begin
                    if (bus.dataValidIn && (beats_q != 9'd0)) begin
                        wr_en   = 1'b1;
                        addr_d  = addr_q + 1'b1;
                        beats_d = beats_q - 9'd1;
                    end
                    if (bus.endTransactionIn) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            valid_q <= valid_d;
            end_q   <= end_d;
            err_q   <= err_d;
        end
    end

    // Memory array stays unreset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[addr_q][8*i +: 8] <= bus.addressDataIn[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[addr_q];
        end
    end

    assign bus.addressDataOut    = valid_q ? rd_data_q : 32'd0;
    assign bus.dataValidOut      = valid_q;
    assign bus.endTransactionOut = end_q;
    assign bus.busErrorOut       = err_q;
endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: writes, reads, wrap, decode, error,
// byte enables, abort and mid-transaction reset.
module tb_bus_sram_slave;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bus_sram_slave_if bus ();

    bus_sram_slave dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

`ifdef BUS_SRAM_BYTE_ENABLE_EN
    localparam logic [31:0] BE_EXP = 32'h1122CCDD;
`else
    localparam logic [31:0] BE_EXP = 32'hAABBCCDD;
`endif

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.beginTransactionIn = 1'b0;
        bus.addressDataIn      = 32'd0;
        bus.readNotWriteIn     = 1'b0;
        bus.burstSizeIn        = 8'd0;
        bus.byteEnablesIn      = 4'd0;
        bus.dataValidIn        = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.busErrorIn         = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                             input logic e, input logic er);
        checks++;
        assert (bus.dataValidOut === v) else begin
            errors++;
            $error("FAIL %s dataValidOut observed %b expected %b", tag, bus.dataValidOut, v);
        end
        checks++;
        assert (bus.addressDataOut === d) else begin
            errors++;
            $error("FAIL %s addressDataOut observed %h expected %h", tag, bus.addressDataOut, d);
        end
        checks++;
        assert (bus.endTransactionOut === e) else begin
            errors++;
            $error("FAIL %s endTransactionOut observed %b expected %b", tag, bus.endTransactionOut, e);
        end
        checks++;
        assert (bus.busErrorOut === er) else begin
            errors++;
            $error("FAIL %s busErrorOut observed %b expected %b", tag, bus.busErrorOut, er);
        end
    endtask

    task automatic check_zero(input string tag);
        check_out(tag, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [7:0] burst,
                            input int n, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic [3:0] be, input bit end_same);
        logic [31:0] dv [4];
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        cyc();
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = a;
        bus.readNotWriteIn     = 1'b0;
        bus.burstSizeIn        = burst;
        check_zero({tag, "_begin"});
        for (int i = 0; i < n; i++) begin
            cyc();
            idle_inputs();
            bus.dataValidIn      = 1'b1;
            bus.addressDataIn    = dv[i];
            bus.byteEnablesIn    = be;
            bus.endTransactionIn = end_same && (i == n - 1);
            check_zero($sformatf("%s_beat%0d", tag, i));
        end
        if (!end_same) begin
            cyc();
            idle_inputs();
            bus.endTransactionIn = 1'b1;
            check_zero({tag, "_end"});
        end
        cyc();
        idle_inputs();
        check_zero({tag, "_after"});
        $display("write %s addr=%h beats=%0d done", tag, a, n);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input int n,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        cyc();
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = a;
        bus.readNotWriteIn     = 1'b1;
        bus.burstSizeIn        = 8'(n - 1);
        check_zero({tag, "_T"});
        cyc();
        idle_inputs();
        check_zero({tag, "_T1"});
        for (int i = 0; i < n; i++) begin
            cyc();
            check_out($sformatf("%s_beat%0d", tag, i), 1'b1, ev[i], 1'b0, 1'b0);
        end
        cyc();
        check_out({tag, "_end"}, 1'b0, 32'd0, 1'b1, 1'b0);
        cyc();
        check_zero({tag, "_idle"});
        $display("read %s addr=%h beats=%0d done", tag, a, n);
    endtask

    initial begin
        idle_inputs();
        #1;
        check_zero("reset_async");
        cyc();
        cyc();
        check_zero("reset_held");
        reset = 1'b0;
        cyc();
        check_zero("post_reset");

        do_write("wr_burst", 32'h5000_0010, 8'd3, 4,
                 32'h11, 32'h22, 32'h33, 32'h44, 4'hF, 1'b0);
        do_read("rd_burst", 32'h5000_0010, 4, 32'h11, 32'h22, 32'h33, 32'h44);

        do_write("wr_wrap", 32'h5000_07FC, 8'd1, 2,
                 32'hA5, 32'h5A, 32'h0, 32'h0, 4'hF, 1'b1);
        do_read("rd_wrap", 32'h5000_07FC, 2, 32'hA5, 32'h5A, 32'h0, 32'h0);

        // Out-of-window address: nothing may be driven.
        cyc();
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = 32'h6000_0000;
        bus.readNotWriteIn     = 1'b1;
        bus.burstSizeIn        = 8'd3;
        cyc();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            check_zero($sformatf("nodecode_c%0d", i));
            cyc();
        end
        $display("decode miss at 60000000 done");

        // Misaligned in-window address: one-cycle error response.
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = 32'h5000_0002;
        bus.readNotWriteIn     = 1'b1;
        check_zero("misalign_T");
        cyc();
        idle_inputs();
        check_out("misalign_T1", 1'b0, 32'd0, 1'b1, 1'b1);
        cyc();
        check_zero("misalign_T2");
        $display("misaligned 50000002 done");

        do_write("wr_be_full", 32'h5000_0020, 8'd0, 1,
                 32'h1122_3344, 32'h0, 32'h0, 32'h0, 4'hF, 1'b1);
        do_write("wr_be_part", 32'h5000_0020, 8'd0, 1,
                 32'hAABB_CCDD, 32'h0, 32'h0, 32'h0, 4'b0011, 1'b1);
        do_read("rd_be", 32'h5000_0020, 1, BE_EXP, 32'h0, 32'h0, 32'h0);

        // Extra beat beyond the burst length must not reach mem[13].
        do_write("wr_pre13", 32'h5000_0034, 8'd0, 1,
                 32'h99, 32'h0, 32'h0, 32'h0, 4'hF, 1'b1);
        do_write("wr_over", 32'h5000_0030, 8'd0, 2,
                 32'h77, 32'h88, 32'h0, 32'h0, 4'hF, 1'b0);
        do_read("rd_over", 32'h5000_0030, 2, 32'h77, 32'h99, 32'h0, 32'h0);

        // Initiator abort at T+3 of an 8-beat read.
        cyc();
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = 32'h5000_0010;
        bus.readNotWriteIn     = 1'b1;
        bus.burstSizeIn        = 8'd7;
        cyc();
        idle_inputs();
        check_zero("abort_T1");
        cyc();
        check_out("abort_T2", 1'b1, 32'h11, 1'b0, 1'b0);
        cyc();
        check_out("abort_T3", 1'b1, 32'h22, 1'b0, 1'b0);
        bus.endTransactionIn = 1'b1;
        for (int i = 4; i < 12; i++) begin
            cyc();
            idle_inputs();
            check_zero($sformatf("abort_T%0d", i));
        end
        $display("abort of 8-beat read done");

        // Reset pulse at T+3 of a read drops outputs without waiting for a clock.
        cyc();
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = 32'h5000_0010;
        bus.readNotWriteIn     = 1'b1;
        bus.burstSizeIn        = 8'd3;
        cyc();
        idle_inputs();
        cyc();
        check_out("rst_T2", 1'b1, 32'h11, 1'b0, 1'b0);
        cyc();
        check_out("rst_T3", 1'b1, 32'h22, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_zero("rst_mid_async");
        cyc();
        check_zero("rst_mid_held");
        reset = 1'b0;
        cyc();
        check_zero("rst_released");
        $display("reset during read done");
        do_read("rd_after_rst", 32'h5000_0010, 4, 32'h11, 32'h22, 32'h33, 32'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
